// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use, taken branch, data-memory wait.
// Drives register enables/flushes and a sticky memory-timeout error.
module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_addr,
  input  logic        mem_branch_taken,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             mem_stall;
  logic             load_use;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             freeze;
  logic             halt;

  assign mem_stall = mem_access && !dmem_ready;
  assign rs1_hit   = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit   = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use  = ex_mem_read && (ex_rd_addr != 5'd0)
                     && (rs1_hit || rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // A dropped mem_access in MEM_WAIT counts as completion
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    halt         = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (wait_cnt == TO)
            state_nxt = ERR;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      ERR: halt = 1'b1;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (halt) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign err = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_en)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl
// against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        mem_branch_taken;
  logic        mem_access;
  logic        dmem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        err;
  logic [31:0] stall_cnt;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .err(err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: consecutive stalled-access cycles, sticky error, stall tally
  int          m_streak;
  bit          m_err;
  logic [31:0] m_stalls;

  // {pc, ifid, idex, exmem, ifid_f, idex_f, exmem_f, memwb_f, err}
  localparam logic [8:0] V_RST   = 9'b0000_1111_0;
  localparam logic [8:0] V_ERR   = 9'b0000_0000_1;
  localparam logic [8:0] V_FRZ   = 9'b0000_0001_0;
  localparam logic [8:0] V_BR    = 9'b1111_1110_0;
  localparam logic [8:0] V_LU    = 9'b0011_0100_0;
  localparam logic [8:0] V_NORM  = 9'b1111_0000_0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush,
            idex_flush, exmem_flush, memwb_flush, err};
  endfunction

  function automatic logic [8:0] model_vec();
    bit lu;
    lu = ex_mem_read && ex_rd_addr != 0 &&
         ((id_use_rs1 && id_rs1_addr == ex_rd_addr) ||
          (id_use_rs2 && id_rs2_addr == ex_rd_addr));
    if (rst) return V_RST;
    if (m_err) return V_ERR;
    if (mem_access && !dmem_ready) return V_FRZ;
    if (mem_branch_taken) return V_BR;
    if (lu) return V_LU;
    return V_NORM;
  endfunction

  function automatic void model_edge();
    logic [8:0] v;
    v = model_vec();
    if (!v[8]) m_stalls = m_stalls + 32'd1;
    if (!m_err) begin
      if (mem_access && !dmem_ready) m_streak++;
      else m_streak = 0;
      // the access may be stalled at most TIMEOUT+1 cycles in a row
      if (m_streak > TIMEOUT) m_err = 1'b1;
    end
  endfunction

  task automatic idle_inputs();
    id_rs1_addr = 0; id_rs2_addr = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_rd_addr = 0;
    mem_branch_taken = 0; mem_access = 0; dmem_ready = 0;
  endtask

  task automatic step(input string tag,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2,
                      input logic mr, input logic [4:0] rd,
                      input logic br, input logic acc,
                      input logic rdy);
    @(negedge clk);
    id_rs1_addr = r1; id_rs2_addr = r2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd_addr = rd;
    mem_branch_taken = br; mem_access = acc; dmem_ready = rdy;
    #1;
    chk({tag, ".outs"}, 32'(dut_vec()), 32'(model_vec()));
    chk({tag, ".stall_cnt"}, stall_cnt, m_stalls);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst.outs", 32'(dut_vec()), 32'(V_RST));
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    m_err = 0; m_streak = 0; m_stalls = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic normal(input string tag);
    step(tag, 1, 2, 1, 1, 0, 0, 0, 0, 1);
  endtask

  logic [31:0] sc0;

  initial begin
    idle_inputs();
    rst = 1'b1;
    m_err = 0; m_streak = 0; m_stalls = 0;
    #2;
    chk("por.outs", 32'(dut_vec()), 32'(V_RST));
    do_reset();

    // load-use on rs2
    sc0 = stall_cnt;
    step("lu", 0, 5, 0, 1, 1, 5, 0, 0, 0);
    chk("lu.vec", 32'(dut_vec()), 32'(V_LU));
    normal("lu_after");
    chk("lu.delta", stall_cnt - sc0, 32'd1);

    // load to x0
    step("lu_x0", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("lu_x0.vec", 32'(dut_vec()), 32'(V_NORM));

    // branch wins over load-use
    step("br_lu", 0, 5, 0, 1, 1, 5, 1, 0, 0);
    chk("br_lu.vec", 32'(dut_vec()), 32'(V_BR));

    // three-cycle memory wait
    sc0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      step("mw", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("mw.vec", 32'(dut_vec()), 32'(V_FRZ));
    end
    step("mw_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("mw_rdy.vec", 32'(dut_vec()), 32'(V_NORM));
    normal("mw_after");
    chk("mw.delta", stall_cnt - sc0, 32'd3);

    // ready arriving when the wait counter sits at TIMEOUT
    for (int i = 0; i < TIMEOUT; i++)
      step("tr", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("tr_rdy", 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("tr_rdy.vec", 32'(dut_vec()), 32'(V_BR));
    normal("tr_after");
    chk("tr.err", 32'(err), 32'd0);

    // mem_access dropped during a wait
    step("drop0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("drop1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("drop2", 3, 0, 1, 0, 1, 3, 0, 0, 0);
    chk("drop2.vec", 32'(dut_vec()), 32'(V_LU));
    normal("drop_after");

    // timeout into sticky error
    for (int i = 0; i < TIMEOUT + 1; i++)
      step("to", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("to_err", 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("to.err", 32'(err), 32'd1);
    chk("to.vec", 32'(dut_vec()), 32'(V_ERR));
    normal("to_stuck");

    // asynchronous reset out of ERR, between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_err.outs", 32'(dut_vec()), 32'(V_RST));
    chk("arst_err.cnt", stall_cnt, 32'd0);
    m_err = 0; m_streak = 0; m_stalls = 0;
    @(negedge clk);
    rst = 1'b0;
    normal("arst_err_after");

    // asynchronous reset in MEM_WAIT
    step("aw0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("aw1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_mw.outs", 32'(dut_vec()), 32'(V_RST));
    chk("arst_mw.cnt", stall_cnt, 32'd0);
    m_err = 0; m_streak = 0; m_stalls = 0;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    step("arst_mw_after", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("arst_mw.vec", 32'(dut_vec()), 32'(V_BR));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step("rnd",
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of consecutive MEM_WAIT cycles before the error state is entered.
REQ-002 Parameter CNT_W, default 8, is the width of the wait counter, which SHALL be at least clog2(TIMEOUT+1) bits.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_rs1_addr  in  5  rs1 index of the instruction in ID.
REQ-006 id_rs2_addr  in  5  rs2 index of the instruction in ID.
REQ-007 id_use_rs1  in  1  ID instruction reads rs1.
REQ-008 id_use_rs2  in  1  ID instruction reads rs2.
REQ-009 ex_mem_read  in  1  instruction in EX is a load.
REQ-010 ex_rd_addr  in  5  rd index of the instruction in EX.
REQ-011 mem_branch_taken  in  1  branch or jump resolved taken in MEM.
REQ-012 mem_access  in  1  instruction in MEM is a load or store.
REQ-013 dmem_ready  in  1  data memory completes the access this cycle.
REQ-014 pc_en  out  1  PC register update enable.
REQ-015 ifid_en / idex_en / exmem_en  out  1 each  pipeline-register load enables.
REQ-016 ifid_flush / idex_flush / exmem_flush / memwb_flush  out  1 each  load a bubble (NOP, inst 0x00000013, controls 0) into that register.
REQ-017 err  out  1  sticky memory-timeout error flag.
REQ-018 stall_cnt  out  32  count of cycles with pc_en=0, wraps modulo 2^32.

Function
REQ-019 The block SHALL implement states RUN, MEM_WAIT and ERR, held in a register; all pipeline-control outputs SHALL be combinational from the state and the current inputs.
REQ-020 The condition mem_stall SHALL be mem_access && !dmem_ready, evaluated in RUN and MEM_WAIT.
REQ-021 The condition load_use SHALL be ex_mem_read && ex_rd_addr!=0 && ((id_use_rs1 && id_rs1_addr==ex_rd_addr) || (id_use_rs2 && id_rs2_addr==ex_rd_addr)).
REQ-022 Priority SHALL be ERR > mem_stall > mem_branch_taken > load_use > normal.
REQ-023 Normal operation: all enables 1, all flushes 0.
REQ-024 mem_stall (freeze): pc_en, ifid_en, idex_en and exmem_en SHALL be 0, memwb_flush SHALL be 1, and all other flushes SHALL be 0.
REQ-025 Taken branch: all enables SHALL be 1 (the PC loads the target), ifid_flush, idex_flush and exmem_flush SHALL be 1, and memwb_flush SHALL be 0; the branch instruction itself proceeds to WB.
REQ-026 Load-use: pc_en and ifid_en SHALL be 0, idex_en and idex_flush SHALL be 1, and exmem_en and memwb proceed normally; the hazard lasts exactly one cycle per occurrence.
REQ-027 RUN -> MEM_WAIT when mem_stall, with wait_cnt loaded to 1; otherwise the state stays RUN.
REQ-028 MEM_WAIT with dmem_ready=1: outputs SHALL follow REQ-022 with mem_stall=0, the next state SHALL be RUN, and wait_cnt SHALL be cleared.
REQ-029 MEM_WAIT with dmem_ready=0: freeze per REQ-024 and increment wait_cnt; when wait_cnt==TIMEOUT on a non-ready cycle, the next state SHALL be ERR.
REQ-030 A ready response arriving on the same cycle as wait_cnt==TIMEOUT SHALL take precedence over the timeout.
REQ-031 In ERR, all enables SHALL be 0, all flushes SHALL be 0, and err SHALL be 1; ERR is left only by reset.
REQ-032 mem_access dropping to 0 while in MEM_WAIT SHALL be treated as ready (return to RUN).
REQ-033 stall_cnt SHALL increment on every clock edge at which pc_en=0 and rst=0.

Reset
REQ-034 While rst=1, state SHALL be RUN, wait_cnt SHALL be 0, stall_cnt SHALL be 0 and err SHALL be 0.
REQ-035 While rst=1, all enables SHALL be 0 and all flushes SHALL be 1, independent of the inputs.
REQ-036 Reset asserted mid-MEM_WAIT or in ERR SHALL abort to RUN immediately; the first edge after release evaluates inputs normally.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_use_rs2=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle, then normal; stall_cnt +1.
REQ-038 Load to x0: same as REQ-037 with ex_rd_addr=0 -> no stall.
REQ-039 Branch and load_use together: mem_branch_taken=1 with load_use true -> ifid/idex/exmem flush, pc_en=1, no stall.
REQ-040 Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> 3 freeze cycles with memwb_flush=1, RUN on the 4th cycle, stall_cnt=3.
REQ-041 Timeout: TIMEOUT=4 and dmem_ready held 0 -> err=1 after the 4th wait cycle, outputs frozen; a ready on the edge where wait_cnt==4 returns to RUN without error; rst clears err.
REQ-042 Async reset: rst pulsed between clock edges in MEM_WAIT -> outputs take reset values immediately, and state is RUN after release.
